// File: rtl/lsu_pkg.sv
// Shared constants, state encodings and the alignment-check helper for the
// load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam int TIMEOUT_MAX = 255;
    localparam int CNT_W       = $clog2(TIMEOUT_MAX + 1);

    // Illegal size is treated as misaligned so both share the error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store-side enables/replication and
// load-side extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        sign_ext,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data
);

    logic [15:0] lane_s;

    // Store path: enables and lane-replicated write data
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (st_size)
            SZ_BYTE: begin
                be        = 4'b0001 << st_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = st_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = 32'h0000_0000;
            end
        endcase
    end

    // Load path: shift addressed lane down, then extend
    always_comb begin
        lane_s  = 16'(mem_rdata >> {ld_off, 3'b000});
        ld_data = 32'h0000_0000;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{sign_ext & lane_s[7]}}, lane_s[7:0]};
            SZ_HALF: ld_data = {{16{sign_ext & lane_s[15]}}, lane_s};
            SZ_WORD: ld_data = mem_rdata;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one bus transaction per load/store, stalls
// the pipeline while it is outstanding, and returns aligned load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       size_r;
    logic [1:0]       off_r;
    logic             sext_r;
    logic [3:0]       be_s;
    logic [31:0]      wdata_rep_s;
    logic [31:0]      ld_data_s;
    logic             bad_s;
    logic             timeout_s;

    lsu_lane_align u_align (
        .st_size   (size),
        .st_off    (addr[1:0]),
        .wdata     (wdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .ld_size   (size_r),
        .ld_off    (off_r),
        .sign_ext  (sext_r),
        .mem_rdata (mem_rdata),
        .ld_data   (ld_data_s)
    );

    // Request decode, timeout detect and pipeline stall
    always_comb begin
        bad_s     = is_misaligned(size, addr[1:0]);
        timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
        if (state_r == WAIT) begin
            stall = 1'b1;
        end else if (state_r == IDLE) begin
            stall = req;
        end else begin
            stall = 1'b0;
        end
    end

    // FSM, request capture, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            size_r    <= 2'b00;
            off_r     <= 2'b00;
            sext_r    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0000_0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'h0000_0000;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req && bad_s) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= 32'h0000_0000;
                    end else if (req) begin
                        state_r   <= WAIT;
                        cnt_r     <= {CNT_W{1'b0}};
                        size_r    <= size;
                        off_r     <= addr[1:0];
                        sext_r    <= sign_ext;
                        mem_req   <= 1'b1;
                        mem_we    <= we;
                        mem_addr  <= addr[31:2];
                        mem_be    <= be_s;
                        mem_wdata <= wdata_rep_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    // An ack in the timeout cycle still completes cleanly.
                    if (mem_ack && mem_req) begin
                        state_r <= DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        rdata   <= mem_we ? 32'h0000_0000 : ld_data_s;
                    end else if (timeout_s) begin
                        state_r <= DONE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
